// File: rtl/i2c_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : i2c_arbiter                                                |
// | Description : Round-robin arbiter/sequencer sharing one i2c master       |
// |               between N_REQ clients, with a watchdog that pulses the     |
// |               master reset when a transaction hangs.                     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module i2c_arbiter #(
  parameter int N_REQ   = 4,
  parameter int BYTES_W = 3,
  parameter int BYTES_R = 2,
  parameter int TIMEOUT = 65535
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_REQ-1:0]                  req_v,
  input  logic [N_REQ-1:0][7:0]             req_addr,
  input  logic [N_REQ-1:0]                  req_op,
  input  logic [N_REQ-1:0]                  req_ptr,
  input  logic [N_REQ-1:0][BYTES_W-1:0][7:0] req_data,
  output logic [N_REQ-1:0]                  req_ack,
  output logic [N_REQ-1:0]                  rsp_v,
  output logic [BYTES_R-1:0][7:0]           rsp_data,
  output logic                              rsp_err,
  output logic [$clog2(N_REQ)-1:0]          grant_id,
  output logic                              arb_busy,
  output logic                              m_vin,
  output logic                              m_opcode,
  output logic                              m_ptr_set,
  output logic [7:0]                        m_ain,
  output logic [BYTES_W-1:0][7:0]           m_din,
  output logic                              m_rst,
  input  logic                              m_busy,
  input  logic                              m_vout,
  input  logic [BYTES_R-1:0][7:0]           m_dout
);

  localparam int c_IDW = $clog2(N_REQ);
  localparam int c_WDW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_WAIT  = 3'd1;
  localparam logic [2:0] c_RUN   = 3'd2;
  localparam logic [2:0] c_DONE  = 3'd3;
  localparam logic [2:0] c_ABORT = 3'd4;

  localparam logic [N_REQ-1:0] c_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [2:0]              r_state;
  logic [c_IDW-1:0]        r_rr_last;
  logic [c_WDW-1:0]        r_wd;
  logic                    r_rd_seen;
  logic [BYTES_R-1:0][7:0] r_rdata;

  logic [31:0]             w_sum;
  logic [c_IDW-1:0]        w_idx;
  logic [c_IDW-1:0]        w_gnt;
  logic [N_REQ-1:0]        w_gnt_oh;
  logic [N_REQ-1:0]        w_cur_oh;
  logic                    w_wd_exp;
  logic [c_WDW-1:0]        w_wd_inc;

  // Round-robin pick: scan offsets from rr_last+N down to rr_last+1 so the
  // smallest offset (the next client after the last grant) wins.
  always_comb begin
    w_sum = '0;
    w_idx = '0;
    w_gnt = r_rr_last;
    for (int i = N_REQ; i >= 1; i--) begin
      w_sum = 32'(r_rr_last) + 32'(i);
      w_idx = c_IDW'(w_sum % 32'(N_REQ));
      if (req_v[w_idx]) begin
        w_gnt = w_idx;
      end
    end
  end

  // One-hot decodes and saturating watchdog helpers.
  always_comb begin
    w_gnt_oh = c_ONE << w_gnt;
    w_cur_oh = c_ONE << grant_id;
    w_wd_exp = (r_wd == c_WDW'(TIMEOUT - 1));
    w_wd_inc = (r_wd == {c_WDW{1'b1}}) ? r_wd : r_wd + c_WDW'(1);
  end

  // Sequencer: grant, track master handshake, report completion or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= c_IDLE;
      r_rr_last <= c_IDW'(N_REQ - 1);
      r_wd      <= '0;
      r_rd_seen <= 1'b0;
      r_rdata   <= '0;
      req_ack   <= '0;
      rsp_v     <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      grant_id  <= '0;
      arb_busy  <= 1'b0;
      m_vin     <= 1'b0;
      m_opcode  <= 1'b0;
      m_ptr_set <= 1'b0;
      m_ain     <= '0;
      m_din     <= '0;
      m_rst     <= 1'b0;
    end else begin
      req_ack <= '0;
      rsp_v   <= '0;
      m_vin   <= 1'b0;
      m_rst   <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (|req_v) begin
            m_ain     <= req_addr[w_gnt];
            m_opcode  <= req_op[w_gnt];
            m_ptr_set <= req_ptr[w_gnt];
            m_din     <= req_data[w_gnt];
            r_rr_last <= w_gnt;
            grant_id  <= w_gnt;
            req_ack   <= w_gnt_oh;
            m_vin     <= 1'b1;
            r_wd      <= '0;
            r_rd_seen <= 1'b0;
            arb_busy  <= 1'b1;
            r_state   <= c_WAIT;
          end
        end
        c_WAIT: begin
          r_wd <= w_wd_inc;
          if (w_wd_exp) begin
            r_state <= c_ABORT;
          end else if (m_busy) begin
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          r_wd <= w_wd_inc;
          if (m_vout) begin
            r_rdata   <= m_dout;
            r_rd_seen <= 1'b1;
          end
          if (w_wd_exp) begin
            r_state <= c_ABORT;
          end else if (!m_busy) begin
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          rsp_v    <= w_cur_oh;
          rsp_data <= m_opcode ? r_rdata : '0;
          rsp_err  <= m_opcode & ~r_rd_seen;
          arb_busy <= 1'b0;
          r_state  <= c_IDLE;
        end
        c_ABORT: begin
          m_rst    <= 1'b1;
          rsp_v    <= w_cur_oh;
          rsp_err  <= 1'b1;
          rsp_data <= '0;
          arb_busy <= 1'b0;
          r_state  <= c_IDLE;
        end
        default: begin
          arb_busy <= 1'b0;
          r_state  <= c_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_i2c_arbiter                                             |
// | Description : Self-checking bench for i2c_arbiter with a behavioural     |
// |               i2c master model and a round-robin reference model.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_i2c_arbiter;

  localparam int N  = 4;
  localparam int BW = 3;
  localparam int BR = 2;
  localparam int TO = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [N-1:0]            req_v;
  logic [N-1:0][7:0]       req_addr;
  logic [N-1:0]            req_op;
  logic [N-1:0]            req_ptr;
  logic [N-1:0][BW-1:0][7:0] req_data;
  logic [N-1:0]            req_ack;
  logic [N-1:0]            rsp_v;
  logic [BR-1:0][7:0]      rsp_data;
  logic                    rsp_err;
  logic [1:0]              grant_id;
  logic                    arb_busy;
  logic                    m_vin;
  logic                    m_opcode;
  logic                    m_ptr_set;
  logic [7:0]              m_ain;
  logic [BW-1:0][7:0]      m_din;
  logic                    m_rst;
  logic                    m_busy;
  logic                    m_vout;
  logic [BR-1:0][7:0]      m_dout;

  i2c_arbiter #(.N_REQ(N), .BYTES_W(BW), .BYTES_R(BR), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_v(req_v), .req_addr(req_addr), .req_op(req_op), .req_ptr(req_ptr),
    .req_data(req_data), .req_ack(req_ack), .rsp_v(rsp_v),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .grant_id(grant_id),
    .arb_busy(arb_busy), .m_vin(m_vin), .m_opcode(m_opcode),
    .m_ptr_set(m_ptr_set), .m_ain(m_ain), .m_din(m_din), .m_rst(m_rst),
    .m_busy(m_busy), .m_vout(m_vout), .m_dout(m_dout)
  );

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Master model configuration: 0 = normal, 1 = never busy, 2 = hang busy.
  int          cfg_mode = 0;
  int          cfg_len  = 4;
  logic        cfg_vout = 1'b1;
  logic [15:0] cfg_data = 16'h0000;

  // Behavioural i2c master: busy starts the cycle after it sees vin, lasts
  // cfg_len cycles, and on reads pulses vout one cycle before busy drops.
  initial begin
    int   cnt;
    logic start;
    m_busy = 1'b0; m_vout = 1'b0; m_dout = '0; cnt = 0; start = 1'b0;
    forever begin
      @(posedge clk); #2;
      m_vout = 1'b0;
      m_dout = 16'($urandom);
      if (rst || m_rst) begin
        m_busy = 1'b0; cnt = 0; start = 1'b0;
      end else begin
        if (start) begin
          start = 1'b0;
          if (cfg_mode != 1) begin m_busy = 1'b1; cnt = cfg_len; end
        end else if (m_busy && cfg_mode != 2) begin
          cnt--;
          if (cnt <= 0) m_busy = 1'b0;
          else if (cnt == 1 && m_opcode && cfg_vout) begin
            m_vout = 1'b1; m_dout = cfg_data;
          end
        end
        if (m_vin) start = 1'b1;
      end
    end
  end

  // Records the cycle in which the master's busy falls.
  int   fall_cyc = 0;
  initial begin
    logic pb;
    pb = 1'b0;
    forever begin
      @(posedge clk); #3;
      if (pb && !m_busy) fall_cyc = cyc;
      pb = m_busy;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1);
  end

  int rr;  // reference model: last granted client

  function automatic int rr_pick(input logic [N-1:0] m, input int last);
    int idx;
    logic [31:0] iv;
    rr_pick = -1;
    for (int k = N; k >= 1; k--) begin
      idx = (last + k) % N;
      iv  = 32'(idx);
      if (m[iv[1:0]]) rr_pick = idx;
    end
  endfunction

  function automatic logic [63:0] all_outs();
    return {req_ack, rsp_v, rsp_data, rsp_err, grant_id, arb_busy, m_vin,
            m_opcode, m_ptr_set, m_ain, m_din, m_rst};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_v = '0; cfg_mode = 0; cfg_len = 4; cfg_vout = 1'b1;
    tick(); tick();
    rst = 1'b0; rr = N - 1;
    tick();
  endtask

  task automatic wait_ack(input int maxc, output logic ok, output logic [N-1:0] ack,
                          output int acyc);
    ok = 1'b0; ack = '0; acyc = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      if (req_ack != '0) begin ok = 1'b1; ack = req_ack; acyc = cyc; end
    end
  endtask

  task automatic wait_rsp(input int maxc, output logic ok, output logic [N-1:0] v,
                          output logic [15:0] d, output logic e, output logic mr,
                          output int rc, output int nv, output logic st);
    logic [7:0]  a0;
    logic [23:0] d0;
    a0 = m_ain; d0 = m_din;
    ok = 1'b0; v = '0; d = '0; e = 1'b0; mr = 1'b0; rc = 0; nv = 0; st = 1'b1;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      if (m_vin) nv++;
      if (m_ain !== a0 || m_din !== d0) st = 1'b0;
      if (rsp_v != '0) begin
        ok = 1'b1; v = rsp_v; d = rsp_data; e = rsp_err; mr = m_rst; rc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_v = '0; req_addr = '0; req_op = '0; req_ptr = '0; req_data = '0;
    tick(); tick();
    nvec++;
    if (all_outs() !== 64'd0) begin
      nerr++; $display("FAIL reset_outs: got %h, required 0", all_outs());
    end
    rst = 1'b0; rr = N - 1;
    tick(); tick();
    nvec++;
    if (all_outs() !== 64'd0) begin
      nerr++; $display("FAIL idle_outs: got %h, required 0", all_outs());
    end
  endtask

  task automatic test_write();
    logic ok, e, mr, st; logic [N-1:0] ack, v; logic [15:0] d; int ac, rc, nv, t0;
    do_reset();
    req_addr[1] = 8'h48; req_op[1] = 1'b0; req_ptr[1] = 1'b0;
    req_data[1] = {8'h01, 8'h60, 8'hA0};
    req_v = 4'b0010; t0 = cyc;
    wait_ack(20, ok, ack, ac);
    nvec++;
    if (!ok || ack !== 4'b0010 || ac != t0 + 1) begin
      nerr++; $display("FAIL write_ack: ack=%b cyc=%0d, required 0010 cyc=%0d", ack, ac, t0 + 1);
    end
    nvec++;
    if (m_ain !== 8'h48 || m_din !== 24'h0160A0 || m_opcode !== 1'b0 || m_vin !== 1'b1 ||
        arb_busy !== 1'b1 || grant_id !== 2'd1) begin
      nerr++; $display("FAIL write_fields: ain=%h din=%h op=%b vin=%b busy=%b gid=%0d, required 48 0160a0 0 1 1 1",
                       m_ain, m_din, m_opcode, m_vin, arb_busy, grant_id);
    end
    req_v = '0; req_addr[1] = 8'h11; req_data[1] = 24'hDEAD00;
    wait_rsp(100, ok, v, d, e, mr, rc, nv, st);
    nvec++;
    if (!ok || v !== 4'b0010 || e !== 1'b0 || d !== 16'h0 || rc != fall_cyc + 2) begin
      nerr++; $display("FAIL write_rsp: v=%b err=%b data=%h cyc=%0d, required 0010 0 0000 cyc=%0d",
                       v, e, d, rc, fall_cyc + 2);
    end
    nvec++;
    if (!st || nv != 0) begin
      nerr++; $display("FAIL write_stable: stable=%b extra_vin=%0d, required 1 0", st, nv);
    end
  endtask

  task automatic test_read();
    logic ok, e, mr, st; logic [N-1:0] ack, v; logic [15:0] d; int ac, rc, nv;
    do_reset();
    req_addr[0] = 8'h50; req_op[0] = 1'b1; req_ptr[0] = 1'b0; req_data[0] = 24'h0;
    cfg_data = 16'hBEEF; cfg_vout = 1'b1; cfg_len = 5;
    req_v = 4'b0001;
    wait_ack(20, ok, ack, ac);
    req_v = '0;
    wait_rsp(100, ok, v, d, e, mr, rc, nv, st);
    nvec++;
    if (!ok || v !== 4'b0001 || d !== 16'hBEEF || e !== 1'b0) begin
      nerr++; $display("FAIL read_data: v=%b data=%h err=%b, required 0001 beef 0", v, d, e);
    end
    tick();
    nvec++;
    if (rsp_data !== 16'hBEEF) begin
      nerr++; $display("FAIL read_hold: data=%h, required beef", rsp_data);
    end
    cfg_vout = 1'b0;
    req_v = 4'b0001;
    wait_ack(20, ok, ack, ac);
    req_v = '0;
    wait_rsp(100, ok, v, d, e, mr, rc, nv, st);
    nvec++;
    if (!ok || v !== 4'b0001 || e !== 1'b1) begin
      nerr++; $display("FAIL read_novout: v=%b err=%b, required 0001 1", v, e);
    end
    cfg_vout = 1'b1;
  endtask

  task automatic test_contention();
    logic ok, e, mr, st; logic [N-1:0] ack, v; logic [15:0] d; int ac, rc, nv;
    do_reset();
    req_op = '0; req_addr[0] = 8'h20; req_addr[2] = 8'h22;
    req_v = 4'b0101;
    wait_ack(20, ok, ack, ac);
    nvec++;
    if (!ok || ack !== 4'b0001) begin
      nerr++; $display("FAIL cont_first: ack=%b, required 0001", ack);
    end
    req_v[0] = 1'b0;
    wait_rsp(100, ok, v, d, e, mr, rc, nv, st);
    nvec++;
    if (!ok || v !== 4'b0001 || nv != 0) begin
      nerr++; $display("FAIL cont_rsp0: v=%b extra_vin=%0d, required 0001 0", v, nv);
    end
    wait_ack(20, ok, ack, ac);
    nvec++;
    if (!ok || ack !== 4'b0100 || m_ain !== 8'h22) begin
      nerr++; $display("FAIL cont_second: ack=%b ain=%h, required 0100 22", ack, m_ain);
    end
    req_v = '0;
    wait_rsp(100, ok, v, d, e, mr, rc, nv, st);
  endtask

  task automatic test_fairness();
    logic ok, e, mr, st; logic [N-1:0] ack, v, exp; logic [15:0] d; int ac, rc, nv;
    do_reset();
    req_op = '0;
    req_v = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp = 4'b0001 << (k % N);
      wait_ack(30, ok, ack, ac);
      nvec++;
      if (!ok || ack !== exp) begin
        nerr++; $display("FAIL fair_%0d: ack=%b, required %b", k, ack, exp);
      end
      wait_rsp(100, ok, v, d, e, mr, rc, nv, st);
      nvec++;
      if (!ok || v !== exp || nv != 0) begin
        nerr++; $display("FAIL fair_rsp_%0d: v=%b extra_vin=%0d, required %b 0", k, v, nv, exp);
      end
    end
    req_v = '0;
    tick();
  endtask

  task automatic test_timeout();
    logic ok, e, mr, st; logic [N-1:0] ack, v; logic [15:0] d; int ac, rc, nv;
    do_reset();
    cfg_mode = 1;
    req_op[1] = 1'b1; req_op[3] = 1'b0; req_addr[3] = 8'h33;
    req_v = 4'b1010;
    wait_ack(20, ok, ack, ac);
    nvec++;
    if (!ok || ack !== 4'b0010) begin
      nerr++; $display("FAIL to_ack: ack=%b, required 0010", ack);
    end
    req_v[1] = 1'b0;
    wait_rsp(TO + 20, ok, v, d, e, mr, rc, nv, st);
    cfg_mode = 0;
    nvec++;
    if (!ok || v !== 4'b0010 || e !== 1'b1 || d !== 16'h0 || mr !== 1'b1 || rc != ac + TO + 1) begin
      nerr++; $display("FAIL to_rsp: v=%b err=%b data=%h mrst=%b cyc=%0d, required 0010 1 0000 1 cyc=%0d",
                       v, e, d, mr, rc, ac + TO + 1);
    end
    nvec++;
    if (arb_busy !== 1'b0) begin
      nerr++; $display("FAIL to_idle: arb_busy=%b, required 0", arb_busy);
    end
    wait_ack(20, ok, ack, ac);
    nvec++;
    if (!ok || ack !== 4'b1000 || ac != rc + 1) begin
      nerr++; $display("FAIL to_queued: ack=%b cyc=%0d, required 1000 cyc=%0d", ack, ac, rc + 1);
    end
    req_v = '0;
    wait_rsp(100, ok, v, d, e, mr, rc, nv, st);
    nvec++;
    if (!ok || v !== 4'b1000 || e !== 1'b0) begin
      nerr++; $display("FAIL to_queued_rsp: v=%b err=%b, required 1000 0", v, e);
    end
  endtask

  task automatic test_reset_mid_run();
    logic ok, e, mr, st, seen; logic [N-1:0] ack, v; logic [15:0] d; int ac, rc, nv;
    do_reset();
    cfg_mode = 2;
    req_addr[2] = 8'h5A; req_op[2] = 1'b0; req_data[2] = 24'h123456;
    req_v = 4'b0100;
    wait_ack(20, ok, ack, ac);
    req_v = '0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    nvec++;
    if (all_outs() !== 64'd0) begin
      nerr++; $display("FAIL rst_mid_outs: got %h, required 0", all_outs());
    end
    rst = 1'b0; cfg_mode = 0; rr = N - 1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_v != '0) seen = 1'b1;
    end
    nvec++;
    if (seen !== 1'b0) begin
      nerr++; $display("FAIL rst_mid_norsp: rsp_v seen=%b, required 0", seen);
    end
    req_op = '0;
    req_v = 4'b1001;
    wait_ack(20, ok, ack, ac);
    nvec++;
    if (!ok || ack !== 4'b0001) begin
      nerr++; $display("FAIL rst_mid_prio: ack=%b, required 0001", ack);
    end
    req_v = '0;
    wait_rsp(100, ok, v, d, e, mr, rc, nv, st);
  endtask

  task automatic test_random();
    logic ok, e, mr, st; logic [N-1:0] ack, v, pend, exp; logic [15:0] d;
    int ac, rc, nv, g;
    logic [1:0]  gi;
    logic [7:0]  f_addr [N];
    logic        f_op   [N];
    logic        f_ptr  [N];
    logic [23:0] f_data [N];
    logic        f_vout [N];
    int          f_len  [N];
    logic [15:0] f_rd   [N];
    logic        e_err;
    logic [15:0] e_data;
    do_reset();
    for (int r = 0; r < 10; r++) begin
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        f_addr[i] = 8'($urandom_range(1, 127));
        f_op[i]   = 1'($urandom);
        f_ptr[i]  = 1'($urandom);
        f_data[i] = 24'($urandom);
        f_vout[i] = ($urandom_range(0, 3) != 0);
        f_len[i]  = $urandom_range(3, 7);
        f_rd[i]   = 16'($urandom);
        req_addr[i] = f_addr[i]; req_op[i] = f_op[i];
        req_ptr[i]  = f_ptr[i];  req_data[i] = f_data[i];
      end
      req_v = pend;
      while (pend != '0) begin
        g = rr_pick(pend, rr);
        gi = 2'(g);
        exp = 4'b0001 << g;
        wait_ack(20, ok, ack, ac);
        cfg_len = f_len[gi]; cfg_vout = f_vout[gi]; cfg_data = f_rd[gi];
        nvec++;
        if (!ok || ack !== exp || grant_id !== gi) begin
          nerr++; $display("FAIL rnd_grant r%0d: ack=%b gid=%0d, required %b %0d", r, ack, grant_id, exp, g);
        end
        nvec++;
        if (m_ain !== f_addr[gi] || m_din !== f_data[gi] || m_opcode !== f_op[gi] ||
            m_ptr_set !== f_ptr[gi]) begin
          nerr++; $display("FAIL rnd_fields r%0d: ain=%h din=%h op=%b ptr=%b, required %h %h %b %b",
                           r, m_ain, m_din, m_opcode, m_ptr_set, f_addr[gi], f_data[gi], f_op[gi], f_ptr[gi]);
        end
        rr = g;
        pend[gi] = 1'b0;
        req_v[gi] = 1'b0;
        req_addr[gi] = 8'($urandom); req_data[gi] = 24'($urandom);
        e_err  = f_op[gi] & ~f_vout[gi];
        e_data = (f_op[gi] && f_vout[gi]) ? f_rd[gi] : 16'h0;
        wait_rsp(100, ok, v, d, e, mr, rc, nv, st);
        nvec++;
        if (!ok || v !== exp || e !== e_err || (!e_err && d !== e_data)) begin
          nerr++; $display("FAIL rnd_rsp r%0d: v=%b err=%b data=%h, required %b %b %h",
                           r, v, e, d, exp, e_err, e_data);
        end
        nvec++;
        if (!st || nv != 0 || rc != fall_cyc + 2) begin
          nerr++; $display("FAIL rnd_timing r%0d: stable=%b extra_vin=%0d cyc=%0d, required 1 0 cyc=%0d",
                           r, st, nv, rc, fall_cyc + 2);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_v = '0; req_addr = '0; req_op = '0; req_ptr = '0; req_data = '0;
    rr = N - 1;
    test_reset();
    test_write();
    test_read();
    test_contention();
    test_fairness();
    test_timeout();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_arbiter.md
# i2c_arbiter

Round-robin arbiter and sequencer that shares one `i2c` master between `N_REQ` client blocks. It latches one client request, issues a single-cycle start to the master, and holds all master inputs stable for the whole transaction. It then tracks the master's `busy`/`vout` handshake and returns read data and a completion or error status to the granted client. A watchdog recovers a hung master by pulsing its reset.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, range 2..16.
- `BYTES_W`, default 3: write byte count; must equal the master's `BYTES_W`.
- `BYTES_R`, default 2: read byte count; must equal the master's `BYTES_R`.
- `TIMEOUT`, default 65535: watchdog limit in clk cycles per transaction, ≥ 16.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_v` in `[N_REQ-1:0]`: request valid per client; the client holds it until `req_ack`.
- `req_addr` in `[N_REQ-1:0][7:0]`: 7-bit slave address in bits [6:0].
- `req_op` in `[N_REQ-1:0]`: 1 = read, 0 = write.
- `req_ptr` in `[N_REQ-1:0]`: pointer-set only.
- `req_data` in `[N_REQ-1:0][BYTES_W-1:0][7:0]`: write payload.
- `req_ack` out `[N_REQ-1:0]`: one-cycle accept pulse.
- `rsp_v` out `[N_REQ-1:0]`: one-cycle completion pulse.
- `rsp_data` out `[BYTES_R-1:0][7:0]`: read data; valid with `rsp_v`.
- `rsp_err` out 1: error flag; valid with `rsp_v`.
- `grant_id` out `$clog2(N_REQ)`: current or last granted client.
- `arb_busy` out 1: high whenever the state is not IDLE.
- `m_vin`, `m_opcode`, `m_ptr_set` out 1: master control.
- `m_ain` out 8: master slave address.
- `m_din` out `[BYTES_W-1:0][7:0]`: master write data.
- `m_rst` out 1: master reset pulse.
- `m_busy`, `m_vout` in 1: master status.
- `m_dout` in `[BYTES_R-1:0][7:0]`: master read data.

## Operation
- All outputs are registered.
- Reset values:
  - All outputs 0.
  - `rr_last` = `N_REQ-1`, so client 0 has first priority.
  - State = IDLE.
- **IDLE:**
  - If any `req_v` is high, select `g` = the first set bit searching upward from `rr_last+1`, with wrap-around.
  - Latch `req_addr[g]`, `req_op[g]`, `req_ptr[g]`, `req_data[g]` into `m_ain`, `m_opcode`, `m_ptr_set`, `m_din`.
  - Set `rr_last` = `grant_id` = `g`.
  - Pulse `req_ack[g]` and `m_vin` for one cycle.
  - Clear the watchdog counter and the `rd_seen` flag.
  - Go to WAIT_BUSY.
- **WAIT_BUSY:** wait for `m_busy`=1, then go to RUN.
- **RUN:**
  - While `m_vout`=1, capture `m_dout` into the response register and set `rd_seen`.
  - When `m_busy`=0, go to DONE.
- **DONE** (one cycle):
  - Pulse `rsp_v[grant_id]`.
  - `rsp_data` = captured data for reads, 0 for writes.
  - `rsp_err` = `m_opcode & ~rd_seen`, i.e. a read that completed with no `vout` is an error.
  - Return to IDLE.
- **Watchdog:**
  - The counter increments every cycle in WAIT_BUSY and RUN.
  - When it reaches `TIMEOUT-1`, go to ABORT instead of the normal transition.
- **ABORT** (one cycle):
  - `m_rst`=1 for one cycle.
  - `rsp_v[grant_id]`=1, `rsp_err`=1, `rsp_data`=0.
  - Return to IDLE.
- Master outputs `m_ain`, `m_din`, `m_opcode`, `m_ptr_set` hold constant from grant until the next grant.
- Clients may change their fields after `req_ack`.
- A `req_v` deasserted before `req_ack` is withdrawn and never acknowledged.
- `rsp_data` holds its value until the next DONE or ABORT.

## Timing
- Cycle T: `req_v[g]` seen in IDLE.
- T+1: `req_ack[g]`=1, `m_vin`=1, `arb_busy`=1, master fields valid.
- The master asserts `busy` at T+2. The arbiter samples it at T+2 and enters RUN at T+3.
- `m_busy` falling seen at cycle B gives DONE at B+1, with `rsp_v` visible at B+2.
- IDLE resumes at B+2. The earliest next `req_ack` is at B+3.
- Simultaneous requests: exactly one grant per transaction, strictly round-robin. With all `req_v` high continuously, the grant order is 0,1,2,…,`N_REQ-1`,0,…
- `m_vin` is never asserted while `arb_busy`=1 after the grant cycle.
- A `rst` mid-transaction returns the arbiter to IDLE with all outputs 0 on the next cycle. No `rsp_v` is issued for the aborted transaction; the system reset also resets the master.
- Watchdog: `rsp_v` with `rsp_err`=1 appears `TIMEOUT`+1 cycles after `m_vin`, counted when `m_busy` never returns low.
- Watchdog counter width is `$clog2(TIMEOUT+1)`, saturating; it never wraps.

## Test plan
- **Single write:** client 1 requests with addr=0x48, op=0, data={0x01,0x60,0xA0}.
  - Required: `req_ack[1]` at T+1, `m_ain`=0x48, `m_din` stable through the transaction.
  - `rsp_v[1]`=1 with `rsp_err`=0 and `rsp_data`=0, 2 cycles after `busy` falls.
- **Read:** client 0, op=1; the master model returns 0xBEEF with `vout`.
  - Required: `rsp_data`=0xBEEF, `rsp_err`=0.
  - Same read with `vout` suppressed: `rsp_err`=1.
- **Contention:** `req_v`=4'b0101 in the same cycle after reset.
  - Required: client 0 granted first, client 2 second. No overlapping `m_vin`.
- **Fairness:** all 4 `req_v` held high for 8 transactions.
  - Required: grant order 0,1,2,3,0,1,2,3.
- **Timeout:** `TIMEOUT`=32, master model never asserts `busy`.
  - Required: `m_rst` pulse and `rsp_v[g]` with `rsp_err`=1, 33 cycles after `m_vin`, then IDLE.
  - A queued request is granted next.
- **Reset mid-RUN:** assert `rst` while `m_busy`=1.
  - Required: all outputs 0 and `arb_busy`=0 the next cycle, no `rsp_v`. After reset, client 0 has priority.
